stopwatch_core: RTL and testbench

- Consumes the single-cycle tick pulses from the interval tick generator and keeps elapsed time as BCD mm:ss.cc.
- Start/stop, clear and lap controls come from the debounced button pulses.
- The 24-bit BCD output feeds the 7-segment multiplexer.
- With the tick generator at its 10 ms default and TICKS_PER_COUNT=1, one tick equals one centisecond.

---
 rtl/stopwatch_core_if.sv | 21 ++
 rtl/stopwatch_core.sv | 93 +++++++++
 tb/tb_stopwatch_core.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_if.sv
// Control pulses in, BCD time and status out, between the button/tick logic and the stopwatch core.
interface stopwatch_core_if;
  logic        i_tick;
  logic        i_start_stop;
  logic        i_clear;
  logic        i_lap;
  logic [23:0] o_digits;
  logic        o_running;
  logic        o_lap_active;
  logic        o_wrap;

  modport master (
    output i_tick, i_start_stop, i_clear, i_lap,
    input  o_digits, o_running, o_lap_active, o_wrap
  );

  modport slave (
    input  i_tick, i_start_stop, i_clear, i_lap,
    output o_digits, o_running, o_lap_active, o_wrap
  );
endinterface

// File: rtl/stopwatch_core.sv
// BCD mm:ss.cc stopwatch with run/pause, clear, lap freeze and sticky wrap flag.
// Count changes on the edge that samples a qualifying tick; o_digits has no extra stage; no backpressure.
module stopwatch_core #(
  parameter int TICKS_PER_COUNT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  stopwatch_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_COUNT - 1);

  state_t      state;
  logic [23:0] count;
  logic [23:0] snap;
  logic [23:0] count_inc;
  logic [7:0]  presc;
  logic        running;
  logic        lap_active;
  logic        wrap;
  logic        carry;
  logic        carry_out;

  // Ripple a +1 through the six nibbles; tens of seconds/minutes roll at 5.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == (((i == 3) || (i == 5)) ? 4'd5 : 4'd9)) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    carry_out = carry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_clear) begin
      state      <= IDLE;
      count      <= '0;
      snap       <= '0;
      presc      <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      // Tick qualification uses the state held before this cycle's transition.
      if (bus.i_tick && (state == RUNNING)) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          count <= count_inc;
          if (carry_out) wrap <= 1'b1;
        end else begin
          presc <= presc + 8'd1;
        end
      end

      if (bus.i_lap && (state != IDLE)) begin
        lap_active <= ~lap_active;
        if (!lap_active) snap <= count;
      end

      if (bus.i_start_stop) begin
        case (state)
          IDLE, PAUSED: begin
            state   <= RUNNING;
            running <= 1'b1;
          end
          RUNNING: begin
            state   <= PAUSED;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_digits     = lap_active ? snap : count;
  assign bus.o_running    = running;
  assign bus.o_lap_active = lap_active;
  assign bus.o_wrap       = wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Drives a TICKS_PER_COUNT=1 and a TICKS_PER_COUNT=4 stopwatch in lockstep against an integer-centisecond model.
module tb_stopwatch_core;

  localparam int TPC [2] = '{1, 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_core_if if0 ();
  stopwatch_core_if if1 ();

  stopwatch_core #(.TICKS_PER_COUNT(1)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  stopwatch_core #(.TICKS_PER_COUNT(4)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

  typedef struct {
    string       tag;
    logic [23:0] dig  [2];
    logic        run  [2];
    logic        lap  [2];
    logic        wrap [2];
  } exp_t;

  exp_t sb [$];

  int n_vec = 0;
  int n_err = 0;

  // Model state: 0 idle, 1 running, 2 paused
  int m_st    [2];
  int m_cs    [2];
  int m_presc [2];
  int m_snap  [2];
  bit m_lap   [2];
  bit m_wrap  [2];

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bcd(input int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cs[k] = 0; m_presc[k] = 0;
      m_snap[k] = 0; m_lap[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic t, input logic s, input logic c, input logic l);
    int old;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_st[k] = 0; m_cs[k] = 0; m_presc[k] = 0;
        m_snap[k] = 0; m_lap[k] = 1'b0; m_wrap[k] = 1'b0;
      end else begin
        old = m_cs[k];
        if (t && m_st[k] == 1) begin
          if (m_presc[k] == TPC[k] - 1) begin
            m_presc[k] = 0;
            m_cs[k]    = m_cs[k] + 1;
            if (m_cs[k] == 360000) begin
              m_cs[k]   = 0;
              m_wrap[k] = 1'b1;
            end
          end else begin
            m_presc[k] = m_presc[k] + 1;
          end
        end
        if (l && m_st[k] != 0) begin
          if (!m_lap[k]) m_snap[k] = old;
          m_lap[k] = !m_lap[k];
        end
        if (s) m_st[k] = (m_st[k] == 1) ? 2 : 1;
      end
    end
  endtask

  function automatic exp_t model_exp(input string tag);
    exp_t e;
    e.tag = tag;
    for (int k = 0; k < 2; k++) begin
      e.dig[k]  = bcd(m_lap[k] ? m_snap[k] : m_cs[k]);
      e.run[k]  = (m_st[k] == 1);
      e.lap[k]  = m_lap[k];
      e.wrap[k] = m_wrap[k];
    end
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, "/dut0/digits"},  if0.o_digits,              e.dig[0]);
    chk({e.tag, "/dut0/running"}, {23'd0, if0.o_running},    {23'd0, e.run[0]});
    chk({e.tag, "/dut0/lap"},     {23'd0, if0.o_lap_active}, {23'd0, e.lap[0]});
    chk({e.tag, "/dut0/wrap"},    {23'd0, if0.o_wrap},       {23'd0, e.wrap[0]});
    chk({e.tag, "/dut1/digits"},  if1.o_digits,              e.dig[1]);
    chk({e.tag, "/dut1/running"}, {23'd0, if1.o_running},    {23'd0, e.run[1]});
    chk({e.tag, "/dut1/lap"},     {23'd0, if1.o_lap_active}, {23'd0, e.lap[1]});
    chk({e.tag, "/dut1/wrap"},    {23'd0, if1.o_wrap},       {23'd0, e.wrap[1]});
  endtask

  task automatic drive(input logic t, input logic s, input logic c, input logic l);
    if0.i_tick = t; if0.i_start_stop = s; if0.i_clear = c; if0.i_lap = l;
    if1.i_tick = t; if1.i_start_stop = s; if1.i_clear = c; if1.i_lap = l;
  endtask

  task automatic step(input logic t, input logic s, input logic c, input logic l,
                      input bit chk_en, input string tag);
    @(negedge clk);
    drive(t, s, c, l);
    model_step(t, s, c, l);
    if (chk_en) sb.push_back(model_exp(tag));
    @(posedge clk);
    #1;
    if (chk_en) compare_out();
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, (i == n - 1), tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    sb.push_back(model_exp(tag));
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start(input string tag);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic clear(input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, tag);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    do_reset("reset");

    start("basic_start");
    ticks(123, "basic_123");

    clear("carry_clear");
    start("carry_start");
    ticks(5999, "carry_5999");
    ticks(1, "carry_6000");
    ticks(6000, "carry_12000");

    clear("wrap_clear");
    start("wrap_start");
    ticks(360000, "wrap_full");
    ticks(5, "wrap_plus5");
    clear("wrap_cleared");

    start("pause_start");
    ticks(50, "pause_50");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pause_stop");
    ticks(20, "pause_ignored");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pause_resume");
    ticks(10, "pause_60");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pause_tick_and_stop");
    ticks(3, "pause_after_tick_stop");

    clear("lap_clear");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "lap_idle_ignored");
    start("lap_start");
    ticks(30, "lap_30");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "lap_freeze");
    ticks(40, "lap_frozen");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "lap_pause_keeps");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "lap_resume");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "lap_release");

    clear("prio_clear");
    start("prio_start");
    ticks(45, "prio_45");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "prio_clear_wins");
    ticks(5, "prio_idle_ticks");

    start("presc_start");
    ticks(7, "presc_7");
    ticks(1, "presc_8");

    clear("rst_clear");
    start("rst_start");
    ticks(20, "rst_20");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rst_lap");
    do_reset("rst_midrun");
    ticks(4, "rst_idle_ticks");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
